// File: rtl/fsm_step_ctrl.sv
// Sequencing controller for the table-driven Moore FSMs: single-step, free-run
// and run-N advance enables, state-load pulses and a state breakpoint.
module fsm_step_ctrl #(
  parameter int STATE_W = 3,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_btn,
  input  logic               run_btn,
  input  logic               runn_btn,
  input  logic               halt_btn,
  input  logic               load_btn,
  input  logic [STATE_W-1:0] load_value,
  input  logic [DIV_W-1:0]   period,
  input  logic [CNT_W-1:0]   n_steps,
  input  logic               bp_en,
  input  logic [STATE_W-1:0] bp_state,
  input  logic [STATE_W-1:0] fsm_state,
  output logic               ctrl_en,
  output logic               load_en,
  output logic [STATE_W-1:0] load_state,
  output logic [1:0]         mode,
  output logic [CNT_W-1:0]   step_count,
  output logic               bp_hit
);

  typedef enum logic [1:0] {
    MODE_HALT  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_RUN_N = 2'd2
  } mode_t;

  mode_t              mode_q, mode_d;
  logic               ctrl_en_q, ctrl_en_d;
  logic               load_en_q, load_en_d;
  logic [STATE_W-1:0] load_state_q, load_state_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;
  logic               bp_hit_q, bp_hit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   per_q, per_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               pulse_prev_q, pulse_prev_d;
  logic               armed_q, armed_d;
  logic [4:0]         btn_prev_q, btn_prev_d;

  logic [4:0]       btn_vec;
  logic [4:0]       btn_edge;
  logic             step_e, run_e, runn_e, halt_e, load_e;
  logic [DIV_W-1:0] p_eff;
  logic             div_last;
  logic             bp_trip;
  logic             pulse;

  assign btn_vec = {load_btn, halt_btn, runn_btn, run_btn, step_btn};
  // Edges are masked for the first cycle out of reset so a button already
  // held at release only primes its history register.
  assign btn_edge = btn_vec & ~btn_prev_q & {5{armed_q}};
  assign step_e   = btn_edge[0];
  assign run_e    = btn_edge[1];
  assign runn_e   = btn_edge[2];
  assign halt_e   = btn_edge[3];
  assign load_e   = btn_edge[4];

  assign p_eff    = (period < DIV_W'(2)) ? DIV_W'(2) : period;
  assign div_last = (div_q >= (per_q - DIV_W'(1)));
  // fsm_state already reflects the advance made by last cycle's pulse.
  assign bp_trip  = pulse_prev_q & bp_en & (fsm_state == bp_state);

  always_comb begin
    mode_d       = mode_q;
    ctrl_en_d    = 1'b0;
    load_en_d    = 1'b0;
    load_state_d = load_state_q;
    step_count_d = step_count_q;
    bp_hit_d     = bp_hit_q;
    div_d        = div_q;
    per_d        = per_q;
    rem_d        = rem_q;
    pulse_prev_d = ctrl_en_q;
    armed_d      = 1'b1;
    btn_prev_d   = btn_vec;
    pulse        = 1'b0;

    if (halt_e) begin
      mode_d   = MODE_HALT;
      div_d    = '0;
      bp_hit_d = bp_hit_q | bp_trip;
    end else if (load_e) begin
      load_en_d    = 1'b1;
      load_state_d = load_value;
      mode_d       = MODE_HALT;
      step_count_d = '0;
      div_d        = '0;
    end else if (bp_trip) begin
      mode_d   = MODE_HALT;
      bp_hit_d = 1'b1;
      div_d    = '0;
    end else begin
      case (mode_q)
        MODE_HALT: begin
          if (step_e) begin
            pulse    = ~ctrl_en_q;
            bp_hit_d = 1'b0;
          end else if (run_e) begin
            mode_d   = MODE_RUN;
            div_d    = '0;
            per_d    = p_eff;
            bp_hit_d = 1'b0;
          end else if (runn_e) begin
            bp_hit_d = 1'b0;
            if (n_steps != '0) begin
              mode_d = MODE_RUN_N;
              rem_d  = n_steps;
              div_d  = '0;
              per_d  = p_eff;
            end
          end
        end
        MODE_RUN, MODE_RUN_N: begin
          if (div_q == '0) begin
            pulse = 1'b1;
            // The period is re-latched only here, so a change lands at the wrap.
            per_d = p_eff;
            div_d = DIV_W'(1);
            if (mode_q == MODE_RUN_N) begin
              rem_d = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                mode_d = MODE_HALT;
                div_d  = '0;
              end
            end
          end else if (div_last) begin
            div_d = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: mode_d = MODE_HALT;
      endcase
    end

    ctrl_en_d = pulse;
    if (pulse) begin
      step_count_d = step_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_HALT;
      ctrl_en_q    <= 1'b0;
      load_en_q    <= 1'b0;
      load_state_q <= '0;
      step_count_q <= '0;
      bp_hit_q     <= 1'b0;
      div_q        <= '0;
      per_q        <= '0;
      rem_q        <= '0;
      pulse_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      btn_prev_q   <= '0;
    end else begin
      mode_q       <= mode_d;
      ctrl_en_q    <= ctrl_en_d;
      load_en_q    <= load_en_d;
      load_state_q <= load_state_d;
      step_count_q <= step_count_d;
      bp_hit_q     <= bp_hit_d;
      div_q        <= div_d;
      per_q        <= per_d;
      rem_q        <= rem_d;
      pulse_prev_q <= pulse_prev_d;
      armed_q      <= armed_d;
      btn_prev_q   <= btn_prev_d;
    end
  end

  assign ctrl_en    = ctrl_en_q;
  assign load_en    = load_en_q;
  assign load_state = load_state_q;
  assign mode       = mode_q;
  assign step_count = step_count_q;
  assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Bench for fsm_step_ctrl: a small FSM model closes the loop, expected pulse and
// load cycles go into queues that a monitor pops as the controller emits them.
module tb_fsm_step_ctrl;

  logic        clk;
  logic        reset;
  logic        step_btn, run_btn, runn_btn, halt_btn, load_btn;
  logic [2:0]  load_value;
  logic [15:0] period;
  logic [7:0]  n_steps;
  logic        bp_en;
  logic [2:0]  bp_state;
  logic [2:0]  fsm_st;
  logic        ctrl_en, load_en;
  logic [2:0]  load_state;
  logic [1:0]  mode;
  logic [7:0]  step_count;
  logic        bp_hit;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int       at;
    logic [2:0] st;
  } load_exp_t;

  int        exp_pulse[$];
  load_exp_t exp_load[$];

  fsm_step_ctrl dut (
    .clk(clk), .reset(reset),
    .step_btn(step_btn), .run_btn(run_btn), .runn_btn(runn_btn),
    .halt_btn(halt_btn), .load_btn(load_btn),
    .load_value(load_value), .period(period), .n_steps(n_steps),
    .bp_en(bp_en), .bp_state(bp_state), .fsm_state(fsm_st),
    .ctrl_en(ctrl_en), .load_en(load_en), .load_state(load_state),
    .mode(mode), .step_count(step_count), .bp_hit(bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controlled FSM: counts up on each advance, presets on load.
  always @(posedge clk) begin
    if (reset) fsm_st <= 3'd0;
    else if (load_en) fsm_st <= load_state;
    else if (ctrl_en) fsm_st <= fsm_st + 3'd1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int target);
    int guard = 0;
    while (cyc < target && guard < 2000) begin
      tick();
      guard++;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset) begin
        while (exp_pulse.size() > 0 && exp_pulse[0] < cyc) begin
          checks++; errors++;
          $display("FAIL pulse_missing expected ctrl_en at cycle %0d, not observed (now %0d)", exp_pulse[0], cyc);
          void'(exp_pulse.pop_front());
        end
        while (exp_load.size() > 0 && exp_load[0].at < cyc) begin
          checks++; errors++;
          $display("FAIL load_missing expected load_en at cycle %0d, not observed (now %0d)", exp_load[0].at, cyc);
          void'(exp_load.pop_front());
        end
        if (ctrl_en) begin
          checks++;
          if (exp_pulse.size() == 0 || exp_pulse[0] != cyc) begin
            errors++;
            $display("FAIL pulse_unexpected ctrl_en=1 at cycle %0d, expected next at %0d",
                     cyc, (exp_pulse.size() > 0) ? exp_pulse[0] : -1);
          end else begin
            void'(exp_pulse.pop_front());
            $display("pulse cycle %0d step_count %0d", cyc, step_count);
          end
        end
        if (load_en) begin
          checks++;
          if (exp_load.size() == 0 || exp_load[0].at != cyc || exp_load[0].st !== load_state) begin
            errors++;
            $display("FAIL load_unexpected load_en=1 state %0d at cycle %0d, expected at %0d",
                     load_state, cyc, (exp_load.size() > 0) ? exp_load[0].at : -1);
          end else begin
            void'(exp_load.pop_front());
            $display("load cycle %0d state %0d", cyc, load_state);
          end
        end
        if (ctrl_en && load_en) begin
          checks++; errors++;
          $display("FAIL exclusive ctrl_en and load_en both 1 at cycle %0d, required not both", cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step_btn = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("FAIL reset_ctrl_en got %b want 0", ctrl_en); end
    checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL reset_load_en got %b want 0", load_en); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode); end
    checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL reset_step_count got %0d want 0", step_count); end
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
    checks++; if (load_state !== 3'd0) begin errors++; $display("FAIL reset_load_state got %0d want 0", load_state); end
  endtask

  task automatic test_step();
    int c0;
    step_btn = 1'b0;
    tick();
    step_btn = 1'b1;
    c0 = cyc;
    exp_pulse.push_back(c0 + 1);
    tick();
    checks++; if (ctrl_en !== 1'b1) begin errors++; $display("FAIL step_pulse got %b want 1", ctrl_en); end
    checks++; if (step_count !== 8'd1) begin errors++; $display("FAIL step_count got %0d want 1", step_count); end
    tick();
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("FAIL step_width got %b want 0", ctrl_en); end
    repeat (3) tick();
    step_btn = 1'b0;
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL step_mode got %0d want 0", mode); end
  endtask

  task automatic test_run();
    int c0;
    period = 16'd4;
    run_btn = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) exp_pulse.push_back(c0 + 2 + 4 * i);
    tick();
    run_btn = 1'b0;
    checks++; if (mode !== 2'd1) begin errors++; $display("FAIL run_mode got %0d want 1", mode); end
    wait_until(c0 + 11);
    halt_btn = 1'b1;
    tick();
    halt_btn = 1'b0;
    wait_until(c0 + 22);
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL run_halt_mode got %0d want 0", mode); end
    checks++; if (step_count !== 8'd4) begin errors++; $display("FAIL run_step_count got %0d want 4", step_count); end
    period = 16'd0;
    run_btn = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) exp_pulse.push_back(c0 + 2 + 2 * i);
    tick();
    run_btn = 1'b0;
    wait_until(c0 + 7);
    halt_btn = 1'b1;
    tick();
    halt_btn = 1'b0;
    wait_until(c0 + 14);
    checks++; if (step_count !== 8'd7) begin errors++; $display("FAIL run_p0_step_count got %0d want 7", step_count); end
  endtask

  task automatic test_runn();
    int c0;
    period = 16'd3;
    n_steps = 8'd3;
    runn_btn = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) exp_pulse.push_back(c0 + 2 + 3 * i);
    tick();
    runn_btn = 1'b0;
    checks++; if (mode !== 2'd2) begin errors++; $display("FAIL runn_mode got %0d want 2", mode); end
    wait_until(c0 + 16);
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL runn_end_mode got %0d want 0", mode); end
    checks++; if (step_count !== 8'd10) begin errors++; $display("FAIL runn_step_count got %0d want 10", step_count); end
    n_steps = 8'd0;
    runn_btn = 1'b1;
    tick();
    runn_btn = 1'b0;
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL runn_zero_mode got %0d want 0", mode); end
    repeat (10) tick();
    checks++; if (step_count !== 8'd10) begin errors++; $display("FAIL runn_zero_count got %0d want 10", step_count); end
  endtask

  task automatic test_breakpoint();
    int c0;
    load_value = 3'd0;
    load_btn = 1'b1;
    c0 = cyc;
    exp_load.push_back('{at: c0 + 1, st: 3'd0});
    tick();
    load_btn = 1'b0;
    tick();
    bp_en = 1'b1;
    bp_state = 3'd2;
    period = 16'd4;
    run_btn = 1'b1;
    c0 = cyc;
    exp_pulse.push_back(c0 + 2);
    exp_pulse.push_back(c0 + 6);
    tick();
    run_btn = 1'b0;
    wait_until(c0 + 20);
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL bp_mode got %0d want 0", mode); end
    checks++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit got %b want 1", bp_hit); end
    checks++; if (fsm_st !== 3'd2) begin errors++; $display("FAIL bp_fsm_state got %0d want 2", fsm_st); end
    checks++; if (step_count !== 8'd2) begin errors++; $display("FAIL bp_step_count got %0d want 2", step_count); end
    step_btn = 1'b1;
    c0 = cyc;
    exp_pulse.push_back(c0 + 1);
    tick();
    step_btn = 1'b0;
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_clear got %b want 0", bp_hit); end
    repeat (4) tick();
    checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_stays_clear got %b want 0", bp_hit); end
    checks++; if (step_count !== 8'd3) begin errors++; $display("FAIL bp_step_after got %0d want 3", step_count); end
    bp_en = 1'b0;
  endtask

  task automatic test_load();
    int c0;
    period = 16'd3;
    run_btn = 1'b1;
    c0 = cyc;
    exp_pulse.push_back(c0 + 2);
    exp_pulse.push_back(c0 + 5);
    tick();
    run_btn = 1'b0;
    wait_until(c0 + 7);
    load_value = 3'd5;
    load_btn = 1'b1;
    exp_load.push_back('{at: c0 + 8, st: 3'd5});
    tick();
    load_btn = 1'b0;
    checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL load_en got %b want 1", load_en); end
    checks++; if (load_state !== 3'd5) begin errors++; $display("FAIL load_state got %0d want 5", load_state); end
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("FAIL load_no_ctrl got %b want 0", ctrl_en); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL load_mode got %0d want 0", mode); end
    checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL load_step_count got %0d want 0", step_count); end
    repeat (8) tick();
    checks++; if (fsm_st !== 3'd5) begin errors++; $display("FAIL load_fsm_state got %0d want 5", fsm_st); end
  endtask

  task automatic test_back_to_back();
    int c0;
    halt_btn = 1'b1;
    load_btn = 1'b1;
    step_btn = 1'b1;
    load_value = 3'd3;
    tick();
    halt_btn = 1'b0;
    load_btn = 1'b0;
    step_btn = 1'b0;
    checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL prio_load_en got %b want 0", load_en); end
    checks++; if (ctrl_en !== 1'b0) begin errors++; $display("FAIL prio_ctrl_en got %b want 0", ctrl_en); end
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL prio_mode got %0d want 0", mode); end
    tick();
    period = 16'd0;
    n_steps = 8'd255;
    runn_btn = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 255; i++) exp_pulse.push_back(c0 + 2 + 2 * i);
    tick();
    runn_btn = 1'b0;
    wait_until(c0 + 515);
    checks++; if (mode !== 2'd0) begin errors++; $display("FAIL wrap_mode got %0d want 0", mode); end
    checks++; if (step_count !== 8'd255) begin errors++; $display("FAIL wrap_pre got %0d want 255", step_count); end
    step_btn = 1'b1;
    c0 = cyc;
    exp_pulse.push_back(c0 + 1);
    tick();
    step_btn = 1'b0;
    checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL wrap_post got %0d want 0", step_count); end
    repeat (5) tick();
  endtask

  initial begin
    reset = 1'b1;
    step_btn = 1'b0; run_btn = 1'b0; runn_btn = 1'b0; halt_btn = 1'b0; load_btn = 1'b0;
    load_value = 3'd0; period = 16'd0; n_steps = 8'd0; bp_en = 1'b0; bp_state = 3'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_step();
    test_run();
    test_runn();
    test_breakpoint();
    test_load();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (exp_pulse.size() != 0) begin
      errors++;
      $display("FAIL pulse_queue_drain got %0d pending want 0", exp_pulse.size());
    end
    checks++;
    if (exp_load.size() != 0) begin
      errors++;
      $display("FAIL load_queue_drain got %0d pending want 0", exp_load.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
